// File: rtl/keypad_scanner_if.sv
// ULA-facing bus of the keypad scanner: key code, press strobe, held flag.
// The scanner drives it as master; the ULA operand-entry block listens as slave.
interface keypad_scanner_if;
   logic [7:0] data;
   logic       validate;
   logic       key_held;

   modport master (
      output data,
      output validate,
      output key_held
   );

   modport slave (
      input data,
      input validate,
      input key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync/debounce, and key encoding
// into the 8-bit ULA command/digit code with a single strobe per press.
module keypad_scanner #(
   parameter int SCAN_DIV  = 50000,
   parameter int DEB_COUNT = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [3:0] col,
   output logic [3:0] row,
   keypad_scanner_if.master ula
);

   localparam int DW = (DEB_COUNT < 2) ? 1 : $clog2(DEB_COUNT + 1);
   localparam logic [15:0]   DIV_LAST = 16'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_COUNT);
   localparam logic [DW-1:0] DEB_ONE  = DW'(1);

   typedef enum logic [2:0] {
      SCAN,
      DEBOUNCE,
      LOAD,
      EMIT,
      RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    col_s1, col_s2;
   logic [15:0]   div_q;
   logic          tick;
   logic [1:0]    row_idx_q, row_idx_d;
   logic [1:0]    key_col_q, key_col_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [DW-1:0] deb_inc;
   logic [7:0]    data_q, data_d;
   logic [3:0]    act;
   logic          single;
   logic          same_key;
   logic [1:0]    hit_col;

   function automatic logic [7:0] key_code(input logic [1:0] r,
                                           input logic [1:0] c);
      logic [7:0] k;
      unique case ({r, c})
         4'h0: k = 8'd1;
         4'h1: k = 8'd2;
         4'h2: k = 8'd3;
         4'h3: k = 8'd15;
         4'h4: k = 8'd4;
         4'h5: k = 8'd5;
         4'h6: k = 8'd6;
         4'h7: k = 8'd19;
         4'h8: k = 8'd7;
         4'h9: k = 8'd8;
         4'hA: k = 8'd9;
         4'hB: k = 8'd16;
         4'hC: k = 8'd17;
         4'hD: k = 8'd0;
         4'hE: k = 8'd20;
         4'hF: k = 8'd18;
      endcase
      return k;
   endfunction

   // two-flop synchroniser for the asynchronous column lines
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         col_s1 <= 4'hF;
         col_s2 <= 4'hF;
      end else begin
         col_s1 <= col;
         col_s2 <= col_s1;
      end
   end

   assign tick = (div_q == DIV_LAST);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         div_q <= 16'd0;
      end else if (tick) begin
         div_q <= 16'd0;
      end else begin
         div_q <= div_q + 16'd1;
      end
   end

   assign act      = ~col_s2;
   assign single   = (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
   assign same_key = (act == (4'b0001 << key_col_q));
   assign deb_inc  = (deb_cnt_q == DEB_MAX) ? DEB_MAX : deb_cnt_q + DEB_ONE;

   always_comb begin
      hit_col = 2'd0;
      if (single) begin
         unique case (1'b1)
            act[0]: hit_col = 2'd0;
            act[1]: hit_col = 2'd1;
            act[2]: hit_col = 2'd2;
            act[3]: hit_col = 2'd3;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= SCAN;
         row_idx_q <= 2'd0;
         key_col_q <= 2'd0;
         deb_cnt_q <= '0;
         data_q    <= 8'hFF;
      end else begin
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
         key_col_q <= key_col_d;
         deb_cnt_q <= deb_cnt_d;
         data_q    <= data_d;
      end
   end

   // data is written on entry to LOAD so it settles a cycle before validate
   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      key_col_d = key_col_q;
      deb_cnt_d = deb_cnt_q;
      data_d    = data_q;
      unique case (state_q)
         SCAN: begin
            if (tick) begin
               if (single) begin
                  key_col_d = hit_col;
                  deb_cnt_d = DEB_ONE;
                  if (DEB_ONE >= DEB_MAX) begin
                     state_d = LOAD;
                     data_d  = key_code(row_idx_q, hit_col);
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (single && same_key) begin
                  deb_cnt_d = deb_inc;
                  if (deb_inc == DEB_MAX) begin
                     state_d = LOAD;
                     data_d  = key_code(row_idx_q, key_col_q);
                  end
               end else begin
                  state_d   = SCAN;
                  deb_cnt_d = '0;
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
         end
         LOAD: begin
            state_d = EMIT;
         end
         EMIT: begin
            state_d   = RELEASE;
            deb_cnt_d = '0;
         end
         RELEASE: begin
            if (tick) begin
               if (col_s2 == 4'hF) begin
                  deb_cnt_d = deb_inc;
                  if (deb_inc == DEB_MAX) begin
                     state_d   = SCAN;
                     deb_cnt_d = '0;
                     row_idx_d = row_idx_q + 2'd1;
                  end
               end else begin
                  deb_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase
   end

   assign row          = ~(4'b0001 << row_idx_q);
   assign ula.data     = data_q;
   assign ula.validate = (state_q == EMIT);
   assign ula.key_held = (state_q == EMIT) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives col from row,
// the stimulus queues expected codes and a monitor checks each strobe.
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_COUNT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  col;
   logic [3:0]  row;
   bit   [15:0] pressed;

   keypad_scanner_if ula ();

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .DEB_COUNT(DEB_COUNT)
   ) dut (
      .CLOCK_50(clk),
      .reset   (rst),
      .col     (col),
      .row     (row),
      .ula     (ula)
   );

   always #5 clk = ~clk;

   // switch matrix: a closed key pulls its column low while its row is driven
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
         end
      end
   end

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] keymap[16];
   logic [7:0] last_code;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   logic       prev_valid = 1'b0;
   logic [7:0] prev_data  = 8'hFF;

   always @(negedge clk) begin
      if (ula.validate === 1'b1) begin
         chk("strobe_width", 32'(prev_valid), 32'd0);
         chk("data_setup", 32'(prev_data), 32'(ula.data));
         chk("held_at_strobe", 32'(ula.key_held), 32'd1);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: got data %0d want no strobe",
                     ula.data);
         end else begin
            chk("strobe_data", 32'(ula.data), 32'(exp_q.pop_front()));
         end
      end
      prev_valid <= ula.validate;
      prev_data  <= ula.data;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_key(input int k, input int hold);
      pressed[k] = 1'b1;
      exp_q.push_back(keymap[k]);
      last_code = keymap[k];
      cyc(hold);
      chk("held_before_release", 32'(ula.key_held), 32'd1);
      pressed[k] = 1'b0;
      cyc(40);
      chk("release_done", 32'(ula.key_held), 32'd0);
      chk("strobe_seen", 32'(exp_q.size()), 32'd0);
      chk("data_hold", 32'(ula.data), 32'(last_code));
   endtask

   task automatic tap_key(input int k, input int len);
      pressed[k] = 1'b1;
      cyc(len);
      pressed[k] = 1'b0;
      cyc(30);
      chk("tap_ignored_held", 32'(ula.key_held), 32'd0);
      chk("tap_ignored_data", 32'(ula.data), 32'(last_code));
   endtask

   task automatic multi_key(input int k1, input int k2);
      pressed[k1] = 1'b1;
      exp_q.push_back(keymap[k1]);
      last_code = keymap[k1];
      cyc(70);
      pressed[k2] = 1'b1;
      cyc(40);
      chk("multi_held", 32'(ula.key_held), 32'd1);
      pressed[k1] = 1'b0;
      pressed[k2] = 1'b0;
      cyc(40);
      chk("multi_released", 32'(ula.key_held), 32'd0);
      chk("multi_strobes", 32'(exp_q.size()), 32'd0);
      chk("multi_data", 32'(ula.data), 32'(last_code));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [3:0] r0;
      logic [3:0] exp_row;
      bit         found;
      int         kind, k1, k2;

      keymap = '{8'd1,  8'd2, 8'd3,  8'd15,
                 8'd4,  8'd5, 8'd6,  8'd19,
                 8'd7,  8'd8, 8'd9,  8'd16,
                 8'd17, 8'd0, 8'd20, 8'd18};
      last_code = 8'hFF;
      pressed   = '0;
      rst       = 1'b1;
      cyc(3);
      chk("reset_row", 32'(row), 32'hE);
      chk("reset_data", 32'(ula.data), 32'hFF);
      chk("reset_validate", 32'(ula.validate), 32'd0);
      chk("reset_held", 32'(ula.key_held), 32'd0);
      rst = 1'b0;

      // idle rotation: row index advances once every SCAN_DIV cycles
      for (int i = 0; i < 5; i++) begin
         exp_row = ~(4'b0001 << (i % 4));
         chk("idle_rotation", 32'(row), 32'(exp_row));
         cyc(SCAN_DIV);
      end
      chk("idle_data", 32'(ula.data), 32'hFF);

      press_key(5, 80);

      press_key(15, 70);
      press_key(3, 70);
      press_key(7, 70);
      press_key(8, 70);
      chk("seq_last_data", 32'(ula.data), 32'd7);

      // bounce: alternate each tick period, then settle closed
      for (int i = 0; i < 5; i++) begin
         pressed[0] = 1'b1;
         cyc(SCAN_DIV);
         pressed[0] = 1'b0;
         cyc(SCAN_DIV);
      end
      chk("bounce_no_strobe", 32'(ula.key_held), 32'd0);
      press_key(0, 80);

      // ghost: two columns on the same row
      pressed[8]  = 1'b1;
      pressed[10] = 1'b1;
      cyc(8);
      for (int i = 0; i < 3; i++) begin
         r0 = row;
         cyc(SCAN_DIV);
         chk("ghost_rotate", 32'(row != r0), 32'd1);
      end
      cyc(40);
      chk("ghost_held", 32'(ula.key_held), 32'd0);
      pressed[8]  = 1'b0;
      pressed[10] = 1'b0;
      cyc(20);
      chk("ghost_data", 32'(ula.data), 32'(last_code));

      multi_key(9, 10);

      // reset in the middle of debounce discards the press
      pressed[13] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         cyc(1);
         if (dut.deb_cnt_q == 2 && !ula.key_held) found = 1'b1;
      end
      chk("deb2_reached", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      chk("midreset_row", 32'(row), 32'hE);
      chk("midreset_data", 32'(ula.data), 32'hFF);
      chk("midreset_validate", 32'(ula.validate), 32'd0);
      chk("midreset_held", 32'(ula.key_held), 32'd0);
      cyc(3);
      rst = 1'b0;
      press_key(13, 80);

      for (int it = 0; it < 24; it++) begin
         kind = $urandom_range(0, 3);
         k1   = $urandom_range(0, 15);
         k2   = (k1 + $urandom_range(1, 15)) % 16;
         unique case (kind)
            0, 1: press_key(k1, $urandom_range(60, 120));
            2: tap_key(k1, $urandom_range(1, 3));
            3: multi_key(k1, k2);
         endcase
         cyc($urandom_range(0, 10));
      end

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
